// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bf16 format constants, the stage-1 class enum and payload
// struct, and the stage-1 normalize/classify helper used by the product
// normalizer (and later by the accumulator).
package bf16_pkg;

    localparam int unsigned BF16_BIAS    = 127;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
    localparam int unsigned BF16_FRAC_W  = 7;

    typedef enum logic [1:0] {
        ZERO,
        INF,
        UNF,
        NORM
    } bf16_class_e;

    // Stage-1 payload: normalized fraction plus round bits, pre-round exponent.
    typedef struct packed {
        logic                   sign;
        logic [9:0]             e;
        logic [BF16_FRAC_W-1:0] frac;
        logic                   guard;
        logic                   sticky;
        bf16_class_e            cls;
    } bf16_s1_t;

    // Normalize the exact 8x8 mantissa product and classify the result.
    // exp_in is a 9-bit window where 384..511 encode -128..-1.
    function automatic bf16_s1_t bf16_normalize(
        input logic        sign,
        input logic [8:0]  exp_in,
        input logic [15:0] mant,
        input logic        is_zero,
        input logic        is_inf
    );
        bf16_s1_t p;
        p      = '0;
        p.sign = sign;
        if (mant[15]) begin
            p.frac   = mant[14:8];
            p.guard  = mant[7];
            p.sticky = |mant[6:0];
            p.e      = {1'b0, exp_in} + 10'd1;
        end else begin
            p.frac   = mant[13:7];
            p.guard  = mant[6];
            p.sticky = |mant[5:0];
            p.e      = {1'b0, exp_in};
        end
        // Flush is decided on the pre-round exponent; no subnormals.
        if (is_zero) begin
            p.cls = ZERO;
        end else if (is_inf) begin
            p.cls = INF;
        end else if ((exp_in[8:7] == 2'b11) || (p.e == 10'd0)) begin
            p.cls = UNF;
        end else begin
            p.cls = NORM;
        end
        return p;
    endfunction

endpackage

// File: rtl/bf16_round_pack.sv
// bf16_round_pack: combinational round-to-nearest-even, pack and flag
// generation for a normalized bf16 stage-1 payload.
// Ports:
//   p_i    : stage-1 payload (sign, pre-round exponent, frac, guard, sticky, class)
//   data_o : packed bf16 {sign, exp[7:0], frac[6:0]}
//   ovf_o  : NORM result saturated to infinity
//   unf_o  : nonzero result flushed to zero
module bf16_round_pack
    import bf16_pkg::*;
(
    input  bf16_s1_t    p_i,
    output logic [15:0] data_o,
    output logic        ovf_o,
    output logic        unf_o
);

    logic                 round_up;
    logic [BF16_FRAC_W:0] sum;
    logic [9:0]           e_rnd;

    always_comb begin
        round_up = p_i.guard & (p_i.sticky | p_i.frac[0]);
        sum      = {1'b0, p_i.frac} + {{BF16_FRAC_W{1'b0}}, round_up};
        // A carry out of the fraction leaves sum[6:0] all-zero, which is the
        // required fraction after bumping the exponent.
        e_rnd    = p_i.e + {9'b0, sum[BF16_FRAC_W]};

        data_o = '0;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        unique case (p_i.cls)
            NORM: begin
                if (e_rnd >= {2'b00, BF16_EXP_MAX}) begin
                    data_o = {p_i.sign, BF16_EXP_MAX, {BF16_FRAC_W{1'b0}}};
                    ovf_o  = 1'b1;
                end else begin
                    data_o = {p_i.sign, e_rnd[7:0], sum[BF16_FRAC_W-1:0]};
                end
            end
            INF: begin
                data_o = {p_i.sign, BF16_EXP_MAX, {BF16_FRAC_W{1'b0}}};
            end
            UNF: begin
                data_o = {p_i.sign, 15'h0};
                unf_o  = 1'b1;
            end
            ZERO: begin
                data_o = {p_i.sign, 15'h0};
            end
            default: begin
                data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/bf16_product_normalizer.sv
// bf16_product_normalizer: two-stage normalize / round / pack pipeline behind
// the bf16 multiplier, valid/ready handshake with full backpressure.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready depends only on pipe state
//                       and out_ready)
//   in_sign, in_exp   : product sign, 9-bit biased exponent window
//   in_mant           : exact 16-bit mantissa product, hidden bits included
//   in_zero, in_inf   : product class flags (zero wins when both set)
//   out_valid/out_ready : output handshake
//   out_data          : packed bf16 result
//   out_ovf, out_unf  : overflow saturation / underflow flush flags
module bf16_product_normalizer
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp,
    input  logic [15:0] in_mant,
    input  logic        in_zero,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_unf
);

    logic        s1_valid_q, s1_valid_d;
    bf16_s1_t    s1_q, s1_d;
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] data_q, data_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        adv1, adv2;
    logic [15:0] rp_data;
    logic        rp_ovf, rp_unf;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    bf16_round_pack u_round_pack (
        .p_i    (s1_q),
        .data_o (rp_data),
        .ovf_o  (rp_ovf),
        .unf_o  (rp_unf)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = bf16_normalize(in_sign, in_exp, in_mant, in_zero, in_inf);
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            // Bubbles leave the output payload untouched.
            if (s1_valid_q) begin
                data_d = rp_data;
                ovf_d  = rp_ovf;
                unf_d  = rp_unf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule

// File: tb/tb_bf16_product_normalizer.sv
// tb_bf16_product_normalizer: directed-vector bench for the bf16 product
// normalizer. Expected results are hand-computed constants queued per accepted
// beat; the monitor compares the output head against the queue every cycle it
// is valid (which also covers stability under stall).
module tb_bf16_product_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [15:0] in_mant;
    logic        in_zero;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    typedef struct {
        string       tag;
        logic [17:0] res;   // {data, ovf, unf}
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned n_rx;
    int unsigned stall_seen;
    int unsigned n0;

    bf16_product_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_zero   (in_zero),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send(input string tag, input logic sg, input logic [8:0] ex,
                        input logic [15:0] mn, input logic z, input logic nf,
                        input logic [15:0] xd, input logic xo, input logic xu);
        int unsigned waited;
        exp_t        item;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = sg;
        in_exp   = ex;
        in_mant  = mn;
        in_zero  = z;
        in_inf   = nf;
        #2;
        waited = 0;
        while (!in_ready && waited < 50) begin
            stall_seen++;
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            chk({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
        end else begin
            item.tag = tag;
            item.res = {xd, xo, xu};
            exp_q.push_back(item);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    // Output monitor: head of the expected queue must be on the output every
    // cycle out_valid is high; it retires only when out_ready is high.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk(exp_q[0].tag, {14'b0, out_data, out_ovf, out_unf}, {14'b0, exp_q[0].res});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_rx++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        n_rx       = 0;
        stall_seen = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = '0;
        in_mant    = '0;
        in_zero    = 1'b0;
        in_inf     = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_data",  {16'b0, out_data},  32'd0);
        chk("rst_flags",     {30'b0, out_ovf, out_unf}, 32'd0);
        rst = 1'b0;

        // Directed values, back-to-back with no backpressure.
        send("one",       1'b0, 9'd127, 16'h4000, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0);
        send("mul_2p25",  1'b0, 9'd127, 16'h9000, 1'b0, 1'b0, 16'h4010, 1'b0, 1'b0);
        send("tie_even0", 1'b0, 9'd127, 16'h4040, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0);
        send("tie_odd",   1'b0, 9'd127, 16'h40C0, 1'b0, 1'b0, 16'h3F82, 1'b0, 1'b0);
        send("sticky_up", 1'b0, 9'd127, 16'h4041, 1'b0, 1'b0, 16'h3F81, 1'b0, 1'b0);
        send("rnd_carry", 1'b0, 9'd127, 16'h7FC0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0);
        send("ovf",       1'b0, 9'd254, 16'h8000, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0);
        send("carry_254", 1'b1, 9'd253, 16'h7FC0, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b0);
        send("carry_ovf", 1'b0, 9'd254, 16'h7FC0, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0);
        send("neg_unf",   1'b1, 9'h181, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send("e0_unf",    1'b0, 9'd0,   16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        send("e0_bump",   1'b0, 9'd0,   16'h8000, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0);
        send("neg_zero",  1'b1, 9'd127, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0);
        send("pos_inf",   1'b0, 9'd127, 16'h4000, 1'b0, 1'b1, 16'h7F80, 1'b0, 1'b0);
        send("zero_inf",  1'b0, 9'd127, 16'h4000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        idle();
        chk("stream_no_stall", stall_seen, 32'd0);
        wait_drain("drain_directed");

        // Backpressure: out_ready low for cycles 3..6 of a 6-beat stream.
        stall_seen = 0;
        n0         = n_rx;
        fork
            begin
                send("bp0", 1'b0, 9'd127, 16'h4000, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0);
                send("bp1", 1'b0, 9'd127, 16'h9000, 1'b0, 1'b0, 16'h4010, 1'b0, 1'b0);
                send("bp2", 1'b0, 9'd127, 16'h40C0, 1'b0, 1'b0, 16'h3F82, 1'b0, 1'b0);
                send("bp3", 1'b0, 9'd127, 16'h7FC0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0);
                send("bp4", 1'b1, 9'd127, 16'h4041, 1'b0, 1'b0, 16'hBF81, 1'b0, 1'b0);
                send("bp5", 1'b0, 9'h010, 16'h4000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0);
                idle();
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    @(negedge clk);
                    out_ready = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
                end
            end
        join
        chk("bp_in_ready_dropped", {31'b0, (stall_seen != 0)}, 32'd1);
        wait_drain("drain_bp");
        chk("bp_count", n_rx - n0, 32'd6);

        // Reset with both stages full and the output stalled.
        @(negedge clk);
        out_ready = 1'b0;
        send("rs_a", 1'b0, 9'd127, 16'h4000, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0);
        send("rs_b", 1'b0, 9'd127, 16'h9000, 1'b0, 1'b0, 16'h4010, 1'b0, 1'b0);
        idle();
        #2;
        chk("full_in_ready",  {31'b0, in_ready},  32'd0);
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_data",  {16'b0, out_data},  32'd0);
        chk("arst_flags",     {30'b0, out_ovf, out_unf}, 32'd0);
        chk("arst_in_ready",  {31'b0, in_ready},  32'd1);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: accepted at the next posedge, visible two cycles later.
        send("lat", 1'b0, 9'd127, 16'h9000, 1'b0, 1'b0, 16'h4010, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("lat_c1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #2;
        chk("lat_c2_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_c2_data",  {16'b0, out_data},  32'h4010);
        wait_drain("drain_lat");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bf16_product_normalizer.md
# bf16_product_normalizer

Pipelined normalize/round/pack stage sitting directly downstream of the bf16 multiplier in the PE datapath. Consumes the raw multiplier outputs (sign, biased 9-bit exponent, 16-bit exact mantissa product, zero/inf flags) and produces a packed, round-to-nearest-even bf16 result with overflow/underflow flags. Two register stages with valid/ready handshake and full backpressure.

## Interface
Parameters:
- none. Format constants come from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_sign  in  1  product sign
- in_exp  in  9  biased product exponent, 9-bit two's-complement window (see Operation)
- in_mant  in  16  exact 8x8 mantissa product, hidden bits included
- in_zero  in  1  product is zero
- in_inf  in  1  product is infinite
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  packed bf16 {sign, exp[7:0], frac[6:0]}
- out_ovf  out  1  result saturated to infinity by overflow
- out_unf  out  1  nonzero result flushed to zero

## Operation
- Stage 1 (normalize/classify): if in_mant[15]=1, then frac = in_mant[14:8], guard = in_mant[7], sticky = |in_mant[6:0], e = in_exp+1. Otherwise frac = in_mant[13:7], guard = in_mant[6], sticky = |in_mant[5:0], e = in_exp. e is carried as 10 bits.
- Negative exponent: in_exp[8:7]=2'b11 (values 384..511 encode -128..-1).
- Stage 1 class, in priority order:
  - ZERO if in_zero.
  - INF if in_inf.
  - UNF if the exponent is negative or e==0. Flush decision is made on the pre-round exponent. No subnormals.
  - NORM otherwise.
- Stage 2 (round/pack): round_up = guard & (sticky | frac[0]) (RNE). {c, f} = {1'b0, frac} + round_up. If c=1, e = e+1 and f = 0.
- Stage 2 output, per class:
  - NORM with e ≥ 255 → {sign, 8'hFF, 7'h00}, out_ovf=1.
  - NORM otherwise → {sign, e[7:0], f}.
  - ZERO → {sign, 15'h0}, flags 0.
  - INF → {sign, 8'hFF, 7'h00}, flags 0.
  - UNF → {sign, 15'h0}, out_unf=1.
- NaN is never generated. in_zero & in_inf together resolves to zero.

## Timing
- Latency: 2 cycles from input handshake to out_valid. Throughput: 1 result/cycle with no backpressure.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - adv2 = !s2_valid | out_ready. adv1 = !s1_valid | adv2. in_ready = adv1 (combinational, no combinational path from in_valid).
  - Stage 2 loads stage 1 when adv2. Stage 1 loads the input when adv1.
  - When stalled, a stage's valid and payload hold unchanged.
- out_data, out_ovf and out_unf stay stable while out_valid & !out_ready.
- Simultaneous events: an input accept and an output drain in the same cycle keep the pipe full with no bubble.
- Reset (async, any time including mid-stall): s1_valid=0, s2_valid=0, out_valid=0, out_data=16'h0, out_ovf=0, out_unf=0, in_ready=1 after reset. In-flight beats are discarded.

## Structure
- Shared package bf16_pkg:
  - BF16_BIAS=127, BF16_EXP_MAX=8'hFF, BF16_FRAC_W=7.
  - class enum {ZERO, INF, UNF, NORM}.
  - Struct for the stage-1 payload {sign, e[9:0], frac, guard, sticky, class}.
- One natural sub-module: bf16_round_pack (combinational stage-2 RNE + pack + flags). It is reused later by the accumulator.

## Test plan
- Basic values (in_exp=127 unless stated):
  - in_mant=0x4000 → 0x3F80, flags 0.
  - in_mant=0x9000 → 0x4010 (1.5×1.5=2.25).
- RNE behaviour (in_exp=127):
  - Tie-to-even: in_mant=0x4040 → 0x3F80. in_mant=0x40C0 → 0x3F82.
  - Carry: in_mant=0x7FC0 → 0x4000.
- Overflow/underflow:
  - in_exp=254, in_mant=0x8000 → 0x7F80, out_ovf=1.
  - in_exp=0x181, in_sign=1, in_mant=0x4000 → 0x8000, out_unf=1.
  - in_zero=1, in_sign=1 → 0x8000, flags 0.
- Backpressure: stream 6 beats with out_ready low for cycles 3–6.
  - in_ready drops after 2 beats are held.
  - out_data stays stable while stalled.
  - All 6 results arrive in order with no loss or duplication.
- Reset mid-stall: assert rst with both stages full → out_valid=0 immediately (async). in_ready=1 after release. The next beat emerges exactly 2 cycles after acceptance.
